// File: rtl/mem_dump_display_pkg.sv
// Shared definitions for the memory dump display: FSM states and the
// active-low seven-segment hex glyph table.
package mem_dump_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_SHOW,
    ST_DONE
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index = hex digit; bit 0 = segment a, bit 6 = segment g, 0 lights.
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/mem_dump_display_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import mem_dump_display_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb seg = SEG_LUT[hex];

endmodule

// File: rtl/mem_dump_display.sv
// Walks a block of memory words one at a time and shows each word in hex
// on a multiplexed seven-segment display for a fixed dwell time.
module mem_dump_display
  import mem_dump_display_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter int unsigned       DATA_W       = 32,
  parameter int unsigned       NUM_DIGITS   = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = 'h4,
  parameter int unsigned       NUM_WORDS    = 16,
  parameter int unsigned       DWELL_CYCLES = 100_000_000,
  parameter int unsigned       SCAN_DIV     = 50_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  wrap,
  input  logic                  step,
  output logic                  MemRead,
  output logic [ADDR_W-1:0]     MemBus_Address,
  input  logic [DATA_W-1:0]     MemRead_Data,
  output logic [NUM_DIGITS-1:0] sel,
  output logic [6:0]            leds,
  output logic                  busy,
  output logic                  done
);

  localparam int unsigned IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned DWELL_W = $clog2(DWELL_CYCLES);
  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_WORDS - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 2);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [DATA_W-1:0]   word;
  logic [DWELL_W-1:0]  dwell_cnt;
  logic                dwell_tc;
  logic [SCAN_W-1:0]   scan_cnt;
  logic [DIG_W-1:0]    digit_idx;
  logic                start_q;
  logic                start_armed;
  logic                start_edge;
  logic                advance;
  logic [DATA_W-1:0]   word_shifted;
  logic [3:0]          nibble;
  logic [6:0]          seg;

  // The first cycle after reset cannot see an edge, so a start held high
  // through reset release does not launch a dump.
  always_comb start_edge = start & ~start_q & start_armed;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    advance   = (state == ST_SHOW) && (step || dwell_tc);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_edge) begin
          state_nxt = ST_READ;
          idx_nxt   = '0;
        end
      end
      ST_READ: state_nxt = ST_SHOW;
      ST_SHOW: begin
        if (advance) begin
          if (idx < IDX_LAST) begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = ST_READ;
          end else if (wrap) begin
            idx_nxt   = '0;
            state_nxt = ST_READ;
          end else begin
            state_nxt = ST_DONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      word           <= '0;
      dwell_cnt      <= '0;
      dwell_tc       <= 1'b0;
      start_q        <= 1'b0;
      start_armed    <= 1'b0;
      MemBus_Address <= BASE_ADDR;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      start_q     <= start;
      start_armed <= 1'b1;
      if (state_nxt == ST_READ)
        MemBus_Address <= BASE_ADDR + (ADDR_W'(idx_nxt) << 2);
      if (state == ST_READ)
        word <= MemRead_Data;
      // Terminal count is registered, so SHOW spans exactly DWELL_CYCLES.
      if (state == ST_SHOW && state_nxt == ST_SHOW) begin
        dwell_tc <= (dwell_cnt == DWELL_LAST);
        if (dwell_cnt != DWELL_LAST)
          dwell_cnt <= dwell_cnt + DWELL_W'(1);
      end else begin
        dwell_cnt <= '0;
        dwell_tc  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == DIG_LAST) ? '0 : digit_idx + DIG_W'(1);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    word_shifted = word >> {digit_idx, 2'b00};
    nibble       = word_shifted[3:0];
  end

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (seg)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel  <= '1;
      leds <= SEG_BLANK;
    end else if (state == ST_IDLE) begin
      sel  <= '1;
      leds <= SEG_BLANK;
    end else begin
      sel  <= ~(NUM_DIGITS'(1) << digit_idx);
      leds <= seg;
    end
  end

  always_comb begin
    MemRead = (state == ST_READ);
    busy    = (state == ST_READ) || (state == ST_SHOW);
    done    = (state == ST_DONE);
  end

endmodule

// File: tb/tb_mem_dump_display.sv
// Self-checking bench: a cycle-level behavioural model of the dump/display
// is compared against the DUT every cycle, plus directed literal checks.
module tb_mem_dump_display;

  localparam int unsigned NW    = 3;
  localparam int unsigned DWELL = 4;
  localparam int unsigned SD    = 2;
  localparam int unsigned ND    = 4;
  localparam logic [31:0] BASE  = 32'h4;

  localparam int MI = 0, MR = 1, MS = 2, MD = 3;

  logic        clk, reset, start, wrap, step;
  logic        MemRead;
  logic [31:0] MemBus_Address, MemRead_Data;
  logic [3:0]  sel;
  logic [6:0]  leds;
  logic        busy, done;
  logic [31:0] mem [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          m_state = MI, m_idx = 0, m_show = 0, m_ticks = 0;
  bit          m_prev = 0, m_armed = 0;
  logic [31:0] m_word = '0, m_addr = BASE;
  logic [3:0]  m_sel = 4'hF;
  logic [6:0]  m_leds = 7'h7F;

  mem_dump_display #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .NUM_DIGITS   (ND),
    .BASE_ADDR    (BASE),
    .NUM_WORDS    (NW),
    .DWELL_CYCLES (DWELL),
    .SCAN_DIV     (SD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .wrap           (wrap),
    .step           (step),
    .MemRead        (MemRead),
    .MemBus_Address (MemBus_Address),
    .MemRead_Data   (MemRead_Data),
    .sel            (sel),
    .leds           (leds),
    .busy           (busy),
    .done           (done)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    case (MemBus_Address)
      32'h4:   MemRead_Data = mem[0];
      32'h8:   MemRead_Data = mem[1];
      32'hC:   MemRead_Data = mem[2];
      default: MemRead_Data = 32'hDEAD_BEEF;
    endcase
  end

  function automatic logic [31:0] mem_at(input logic [31:0] a);
    if (a == 32'h4) return mem[0];
    if (a == 32'h8) return mem[1];
    if (a == 32'hC) return mem[2];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  // Expected glyph for word 0x1234 given which digit is enabled.
  function automatic logic [6:0] exp_1234(input logic [3:0] s);
    case (s)
      4'b1110: return 7'h19;
      4'b1101: return 7'h30;
      4'b1011: return 7'h24;
      4'b0111: return 7'h79;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: each posedge, display shows the pre-edge word/digit; the word
  // being shown cycles through memory with DWELL-cycle SHOW periods.
  task automatic model_step();
    int d;
    bit edge_s;
    if (!reset) begin
      m_state = MI; m_idx = 0; m_word = '0; m_show = 0; m_ticks = 0;
      m_prev = 0; m_armed = 0; m_addr = BASE; m_sel = 4'hF; m_leds = 7'h7F;
      return;
    end
    if (m_state == MI) begin
      m_sel = 4'hF; m_leds = 7'h7F;
    end else begin
      d = (m_ticks / SD) % ND;
      m_sel = ~(4'b0001 << d);
      m_leds = seg_of(4'((m_word >> (4 * d)) & 32'hF));
    end
    m_ticks++;
    edge_s = start && !m_prev && m_armed;
    m_prev = start;
    m_armed = 1;
    case (m_state)
      MI, MD: if (edge_s) begin m_idx = 0; m_state = MR; m_addr = BASE; end
      MR: begin m_word = mem_at(m_addr); m_show = 0; m_state = MS; end
      default: begin
        m_show++;
        if (step || m_show == DWELL) begin
          if (m_idx < NW - 1) begin m_idx++; m_state = MR; end
          else if (wrap) begin m_idx = 0; m_state = MR; end
          else m_state = MD;
          if (m_state == MR) m_addr = BASE + 32'(4 * m_idx);
        end
      end
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    check("memread", MemRead, m_state == MR);
    check("addr", MemBus_Address, m_addr);
    check("busy", busy, (m_state == MR) || (m_state == MS));
    check("done", done, m_state == MD);
    check("sel", sel, m_sel);
    check("leds", leds, m_leds);
  end

  task automatic wait_pulse(input string name, output int at);
    int n;
    n = 0;
    while (!MemRead && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({name, "_seen"}, MemRead, 1);
    at = cyc;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done"}, done, 1);
  endtask

  initial begin
    int p0, p1, p2, p3, trans;
    logic [3:0] s_prev;
    reset = 1; start = 0; wrap = 0; step = 0;
    mem[0] = 32'h1234; mem[1] = 32'hABCD; mem[2] = 32'h0F0F;
    s_prev = 4'hF;
    #2 reset = 0;
    repeat (2) @(negedge clk);
    check("rst_memread", MemRead, 0);
    check("rst_addr", MemBus_Address, 32'h4);
    check("rst_sel", sel, 4'hF);
    check("rst_leds", leds, 7'h7F);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    #2 reset = 1;
    repeat (3) @(negedge clk);

    // Single pass, wrap=0
    start = 1;
    wait_pulse("p0", p0);
    check("p0_addr", MemBus_Address, 32'h4);
    trans = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        check("dig_leds", leds, exp_1234(sel));
        if (k > 2 && sel != s_prev) begin
          trans++;
          check("dig_rot", sel, {s_prev[2:0], s_prev[3]});
        end
        s_prev = sel;
      end
    end
    check("dig_trans", trans, 1);
    wait_pulse("p1", p1);
    check("p1_gap", p1 - p0, 5);
    check("p1_addr", MemBus_Address, 32'h8);
    @(negedge clk);
    wait_pulse("p2", p2);
    check("p2_gap", p2 - p1, 5);
    check("p2_addr", MemBus_Address, 32'hC);
    repeat (5) @(negedge clk);
    check("pass_done", done, 1);
    check("pass_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("pass_hold", done, 1);
    check("pass_noread", MemRead, 0);

    // Wrap pass
    start = 0;
    @(negedge clk); #2 reset = 0;
    @(negedge clk); #2 reset = 1;
    repeat (3) @(negedge clk);
    wrap = 1; start = 1;
    wait_pulse("w0", p0); @(negedge clk);
    wait_pulse("w1", p1); @(negedge clk);
    wait_pulse("w2", p2); @(negedge clk);
    wait_pulse("w3", p3);
    check("w3_gap", p3 - p2, 5);
    check("w3_addr", MemBus_Address, 32'h4);
    check("w3_busy", busy, 1);
    check("w3_done", done, 0);
    wrap = 0;
    wait_done("wrap");

    // Restart from DONE, then step tests
    start = 0; @(negedge clk); start = 1;
    wait_pulse("rs", p0);
    check("rs_addr", MemBus_Address, 32'h4);
    @(negedge clk); step = 1;
    @(negedge clk); step = 0;
    check("step_read", MemRead, 1);
    check("step_addr", MemBus_Address, 32'h8);
    repeat (4) @(negedge clk);
    step = 1;
    @(negedge clk); step = 0;
    check("coin_read", MemRead, 1);
    check("coin_addr", MemBus_Address, 32'hC);
    @(negedge clk);
    check("coin_single", MemRead, 0);
    check("coin_busy", busy, 1);
    check("coin_addr2", MemBus_Address, 32'hC);
    wait_done("step");

    // Reset during SHOW of word 1 with start held high
    start = 0; @(negedge clk); start = 1;
    wait_pulse("r0", p0); @(negedge clk);
    wait_pulse("r1", p1);
    check("r1_addr", MemBus_Address, 32'h8);
    repeat (2) @(negedge clk);
    #2 reset = 0;
    #1;
    check("ar_memread", MemRead, 0);
    check("ar_addr", MemBus_Address, 32'h4);
    check("ar_sel", sel, 4'hF);
    check("ar_leds", leds, 7'h7F);
    check("ar_busy", busy, 0);
    check("ar_done", done, 0);
    @(negedge clk); #2 reset = 1;
    repeat (6) @(negedge clk);
    check("held_busy", busy, 0);
    check("held_sel", sel, 4'hF);
    start = 0; @(negedge clk); start = 1;
    wait_pulse("ra", p0);
    check("ra_addr", MemBus_Address, 32'h4);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) start = ~start;
      if ($urandom_range(0, 50) == 0) wrap = ~wrap;
      step = ($urandom_range(0, 12) == 0);
      if ($urandom_range(0, 100) == 0) mem[$urandom_range(0, 2)] = $urandom;
      if ($urandom_range(0, 700) == 0) begin
        #2 reset = 0;
        @(negedge clk);
        #2 reset = 1;
      end
    end
    step = 0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_dump_display.md
MEM_DUMP_DISPLAY -- requirements
Module: mem_dump_display

Interface
REQ-001 Parameter ADDR_W, default 32, memory address width.
REQ-002 Parameter DATA_W, default 32, memory data width, multiple of 4.
REQ-003 Parameter NUM_DIGITS, default 4, number of 7-seg digits (1..DATA_W/4).
REQ-004 Parameter BASE_ADDR, default 32'h4, first dumped byte address.
REQ-005 Parameter NUM_WORDS, default 16, words dumped per pass (>=1).
REQ-006 Parameter DWELL_CYCLES, default 100_000_000, clk cycles each word is shown (>=2).
REQ-007 Parameter SCAN_DIV, default 50_000, clk cycles per digit slot (>=1).
REQ-008 clk  input  1  system clock, rising edge.
REQ-009 reset  input  1  asynchronous, active-low: 0 resets, 1 runs.
REQ-010 start  input  1  level; rising edge while IDLE begins a dump.
REQ-011 wrap  input  1  1 = restart at BASE_ADDR after last word; 0 = stop.
REQ-012 step  input  1  single-cycle pulse; advances to next word immediately.
REQ-013 MemRead  output  1  read strobe to data memory.
REQ-014 MemBus_Address  output  ADDR_W  read byte address.
REQ-015 MemRead_Data  input  DATA_W  combinational memory read data.
REQ-016 sel  output  NUM_DIGITS  one-hot active-low digit enable; bit 0 = least significant nibble.
REQ-017 leds  output  7  active-low segments, leds[0]=a .. leds[6]=g.
REQ-018 busy  output  1  high in READ or SHOW.
REQ-019 done  output  1  high in DONE.

Function
REQ-020 FSM states IDLE, READ, SHOW, DONE.
REQ-021 IDLE -> READ on start rising edge (start registered once, edge = start & ~start_q).
REQ-022 READ lasts exactly one cycle: MemRead=1, MemBus_Address = BASE_ADDR + 4*idx; at its end MemRead_Data captured into word register; -> SHOW.
REQ-023 MemRead=0 and MemBus_Address holds its last value in all other states.
REQ-024 SHOW: dwell counter counts 0..DWELL_CYCLES-2; on terminal count or step=1, advance.
REQ-025 Advance: if idx < NUM_WORDS-1, idx+1 -> READ; else wrap=1 -> idx=0 -> READ; else -> DONE.
REQ-026 step and dwell terminal in same cycle cause exactly one advance.
REQ-027 DONE: display keeps last word; start rising edge -> idx=0, READ; else hold.
REQ-028 start edges in READ/SHOW are ignored.
REQ-029 Scan divider counts 0..SCAN_DIV-1 continuously in every state; on terminal count digit index increments modulo NUM_DIGITS.
REQ-030 sel drives low only bit digit_idx; leds show hex nibble word[4*digit_idx+3 : 4*digit_idx].
REQ-031 Hex decode 0-F standard (b/d lowercase); e.g. 0 -> 7'b1000000, 8 -> 7'b0000000.
REQ-032 In IDLE, sel all ones (blanked) and leds = 7'h7F.
REQ-033 Word register, sel, leds are registered outputs; display lags digit index by one cycle.
REQ-034 Address arithmetic is ADDR_W bits, modulo 2^ADDR_W; idx width clog2(NUM_WORDS), min 1.

Reset
REQ-035 reset=0 asynchronously forces: IDLE, idx=0, word=0, all counters 0, start_q=0, MemRead=0, MemBus_Address=BASE_ADDR, sel all ones, leds=7'h7F, busy=0, done=0.
REQ-036 Reset asserted mid-dump aborts immediately; after release a fresh start edge is required (start held high does not restart).

Structure
REQ-037 Shared package holds state enum, 7-seg hex lookup constant table, segment blank constant.
REQ-038 One sub-module hex_to_seg (4-bit in, 7-bit active-low out, combinational).

Verification
REQ-039 Params NUM_WORDS=3, DWELL_CYCLES=4, SCAN_DIV=2, NUM_DIGITS=4; mem[4]=0x1234, [8]=0xABCD, [12]=0x0F0F; start, wrap=0 -> MemRead pulses at 0x4,0x8,0xC spaced 5 cycles, then done=1.
REQ-040 Same, wrap=1 -> fourth read at 0x4, busy stays high, done never rises.
REQ-041 Word 0x1234 shown -> sel cycles 1110,1101,1011,0111 every 2 cycles with leds 4,3,2,1 codes.
REQ-042 step pulse 1 cycle into SHOW -> next READ next cycle; step coincident with dwell terminal -> single advance.
REQ-043 reset low during SHOW of word 1 -> outputs at reset values at once; start held high through release -> stays IDLE until start toggles.
REQ-044 DONE then new start edge -> reads restart at 0x4.
